// File: rtl/muldiv_sched.sv
// Purpose: arbitrates two pipes onto one shared multi-cycle mul/div unit and tracks the HI/LO hazard.
// Latency: grant is combinational; done pulses LAT+1 cycles after the grant cycle (LAT = MUL_CYCLES or DIV_CYCLES).
// Backpressure: one operation in flight; requests are held off (no grant) in BUSY/DONE and re-granted after done.

package muldiv_pkg;
   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_MUL  = 3'd1,
      OP_MADD = 3'd2,
      OP_DIV  = 3'd3,
      OP_MFHI = 3'd4,
      OP_MFLO = 3'd5,
      OP_MTHI = 3'd6,
      OP_MTLO = 3'd7
   } muldiv_op_t;
endpackage

module muldiv_sched
   import muldiv_pkg::*;
#(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 35,
   parameter int CNT_WIDTH  = 6
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   input  muldiv_op_t  req_op0,
   input  muldiv_op_t  req_op1,
   input  logic [1:0]  req_u,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   input  logic        flush,
   output logic [1:0]  grant,
   output logic        unit_start,
   output muldiv_op_t  unit_op,
   output logic        unit_u,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        done,
   output logic        done_id,
   output logic        hilo_busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_WIDTH-1:0] LP_MUL_LAT = CNT_WIDTH'(MUL_CYCLES);
   localparam logic [CNT_WIDTH-1:0] LP_DIV_LAT = CNT_WIDTH'(DIV_CYCLES);

   logic [1:0]           r_state;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 r_rr;
   logic                 r_start;
   logic                 r_done_id;
   muldiv_op_t           r_unit_op;
   logic                 r_unit_u;
   logic [31:0]          r_unit_a;
   logic [31:0]          r_unit_b;

   logic                 w_long0;
   logic                 w_long1;
   logic                 w_win_id;
   logic                 w_grant_ok;
   logic [CNT_WIDTH-1:0] w_lat;

   // Only MUL/MADD/DIV occupy the unit; everything else is handled elsewhere.
   function automatic logic f_is_long(input muldiv_op_t op);
      return (op == OP_MUL) || (op == OP_MADD) || (op == OP_DIV);
   endfunction

   // Round-robin pick between eligible requesters; a sole requester wins whatever rr says.
   always_comb begin
      w_long0  = req_valid[0] && f_is_long(req_op0);
      w_long1  = req_valid[1] && f_is_long(req_op1);
      w_win_id = 1'b0;
      if (w_long0 && w_long1) begin
         w_win_id = r_rr;
      end else begin
         w_win_id = w_long1;
      end
      // Reset is folded in so grant reads zero while reset_n is held low.
      w_grant_ok = reset_n && (r_state == S_IDLE) && !flush && (w_long0 || w_long1);
      grant      = 2'b00;
      if (w_grant_ok) begin
         grant = w_win_id ? 2'b10 : 2'b01;
      end
      // Latency follows the latched op, which is stable for the whole operation.
      w_lat = (r_unit_op == OP_DIV) ? LP_DIV_LAT : LP_MUL_LAT;
   end

   // Control FSM: flush overrides everything and leaves rr untouched.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_rr      <= 1'b0;
         r_start   <= 1'b0;
         r_done_id <= 1'b0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_start <= 1'b0;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_ok) begin
                  r_state   <= S_BUSY;
                  r_count   <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                  r_start   <= 1'b1;
                  r_done_id <= w_win_id;
                  r_rr      <= ~w_win_id;
               end
            end
            S_BUSY: begin
               // Stop counting at LAT, which is below 2^CNT_WIDTH, so the counter never wraps.
               if (r_count == w_lat) begin
                  r_state <= S_DONE;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_count <= '0;
            end
            default: begin
               r_state <= S_IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

   // Command registers load only on a grant and hold until the next grant.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_unit_op <= OP_NONE;
         r_unit_u  <= 1'b0;
         r_unit_a  <= '0;
         r_unit_b  <= '0;
      end else if (w_grant_ok) begin
         r_unit_op <= w_win_id ? req_op1 : req_op0;
         r_unit_u  <= req_u[w_win_id];
         r_unit_a  <= w_win_id ? req_a1 : req_a0;
         r_unit_b  <= w_win_id ? req_b1 : req_b0;
      end
   end

   assign unit_start = r_start;
   assign unit_op    = r_unit_op;
   assign unit_u     = r_unit_u;
   assign unit_a     = r_unit_a;
   assign unit_b     = r_unit_b;
   assign done       = (r_state == S_DONE) && !flush;
   assign done_id    = r_done_id;
   assign hilo_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_muldiv_sched.sv
// Purpose: directed vectors plus hand-written sequences for the muldiv scheduler.
// Latency: expects done in cycle LAT+1 counted from the grant cycle.
// Backpressure: checks that nothing is granted while an operation is in flight.

module tb_muldiv_sched;
   import muldiv_pkg::*;

   localparam int MULC = 5;
   localparam int DIVC = 35;

   logic        clock;
   logic        reset_n;
   logic [1:0]  req_valid;
   muldiv_op_t  req_op0;
   muldiv_op_t  req_op1;
   logic [1:0]  req_u;
   logic [31:0] req_a0;
   logic [31:0] req_b0;
   logic [31:0] req_a1;
   logic [31:0] req_b1;
   logic        flush;
   logic [1:0]  grant;
   logic        unit_start;
   muldiv_op_t  unit_op;
   logic        unit_u;
   logic [31:0] unit_a;
   logic [31:0] unit_b;
   logic        done;
   logic        done_id;
   logic        hilo_busy;

   int checks = 0;
   int errors = 0;

   muldiv_sched #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_WIDTH(6)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid),
      .req_op0(req_op0), .req_op1(req_op1), .req_u(req_u),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .flush(flush), .grant(grant), .unit_start(unit_start), .unit_op(unit_op),
      .unit_u(unit_u), .unit_a(unit_a), .unit_b(unit_b), .done(done),
      .done_id(done_id), .hilo_busy(hilo_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic [1:0] valid;
      muldiv_op_t op0;
      muldiv_op_t op1;
      logic [1:0] u;
      logic [31:0] a0, b0, a1, b1;
      logic [1:0] exp_grant;
      int         exp_lat;
   } vec_t;

   vec_t tv[10];

   function automatic vec_t mk(input string n, input logic [1:0] v, input muldiv_op_t o0,
                               input muldiv_op_t o1, input logic [1:0] u,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic [1:0] eg, input int lat);
      vec_t r;
      r.name = n; r.valid = v; r.op0 = o0; r.op1 = o1; r.u = u;
      r.a0 = a0; r.b0 = b0; r.a1 = a1; r.b1 = b1; r.exp_grant = eg; r.exp_lat = lat;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_done(input int lat, input logic id, input logic [31:0] ea, input string name);
      int k;
      bit ok;
      k  = 1;
      ok = 1'b1;
      while (done !== 1'b1 && k <= 60) begin
         if (hilo_busy !== 1'b1 || grant !== 2'b00 || unit_a !== ea || (k > 1 && unit_start !== 1'b0))
            ok = 1'b0;
         @(negedge clock); #1;
         k++;
      end
      chk({name, " done_cycle"}, 64'(k), 64'(lat + 1));
      chk({name, " done_id"}, 64'(done_id), 64'(id));
      chk({name, " busy_hold"}, 64'(ok), 64'd1);
      @(negedge clock); #1;
      chk({name, " idle_after"}, 64'({done, hilo_busy}), 64'd0);
   endtask

   initial begin
      int g[$];
      int k;
      int nd;

      tv[0] = mk("mul_r0",     2'b01, OP_MUL,  OP_NONE, 2'b00, 7, 6, 0, 0,            2'b01, MULC);
      tv[1] = mk("mfhi_madd",  2'b11, OP_MFHI, OP_MADD, 2'b10, 1, 2, 32'h55, 32'h66, 2'b10, MULC);
      tv[2] = mk("mul_both_a", 2'b11, OP_MUL,  OP_MUL,  2'b01, 11, 12, 21, 22,       2'b01, MULC);
      tv[3] = mk("mul_both_b", 2'b11, OP_MUL,  OP_MUL,  2'b00, 31, 32, 41, 42,       2'b10, MULC);
      tv[4] = mk("div_sole1",  2'b10, OP_NONE, OP_DIV,  2'b10, 0, 0, 100, 7,         2'b10, DIVC);
      tv[5] = mk("mtlo_only",  2'b01, OP_MTLO, OP_NONE, 2'b00, 9, 9, 0, 0,           2'b00, 0);
      tv[6] = mk("no_req",     2'b00, OP_MUL,  OP_DIV,  2'b00, 1, 1, 1, 1,           2'b00, 0);
      tv[7] = mk("div_mflo",   2'b11, OP_DIV,  OP_MFLO, 2'b01, 90, 3, 5, 5,          2'b01, DIVC);
      tv[8] = mk("madd_sole0", 2'b01, OP_MADD, OP_NONE, 2'b00, 32'hdead, 2, 0, 0,    2'b01, MULC);
      tv[9] = mk("madd_both",  2'b11, OP_MADD, OP_MADD, 2'b11, 13, 14, 15, 16,       2'b10, MULC);

      reset_n = 1'b0; req_valid = 2'b00; req_op0 = OP_NONE; req_op1 = OP_NONE;
      req_u = 2'b00; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; flush = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      chk("reset_outputs", 64'({grant, unit_start, done, done_id, hilo_busy, unit_u}), 64'd0);
      chk("reset_unit_op", 64'(unit_op), 64'(OP_NONE));
      chk("reset_unit_ab", {unit_a, unit_b}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Table-driven vectors; rr evolves 0->1->0->1->0->0->0->0->1->1->0 across them.
      for (int i = 0; i < 10; i++) begin
         logic id;
         @(negedge clock);
         req_valid = tv[i].valid; req_op0 = tv[i].op0; req_op1 = tv[i].op1; req_u = tv[i].u;
         req_a0 = tv[i].a0; req_b0 = tv[i].b0; req_a1 = tv[i].a1; req_b1 = tv[i].b1;
         #1;
         chk({tv[i].name, " grant"}, 64'(grant), 64'(tv[i].exp_grant));
         if (tv[i].exp_grant != 2'b00) begin
            id = tv[i].exp_grant[1];
            @(negedge clock);
            req_valid = 2'b00;
            #1;
            chk({tv[i].name, " start"}, 64'(unit_start), 64'd1);
            chk({tv[i].name, " op"}, 64'(unit_op), 64'(id ? tv[i].op1 : tv[i].op0));
            chk({tv[i].name, " u"}, 64'(unit_u), 64'(tv[i].u[id]));
            chk({tv[i].name, " ab"}, {unit_a, unit_b},
                id ? {tv[i].a1, tv[i].b1} : {tv[i].a0, tv[i].b0});
            wait_done(tv[i].exp_lat, id, id ? tv[i].a1 : tv[i].a0, tv[i].name);
         end else begin
            @(negedge clock);
            req_valid = 2'b00;
            #1;
            chk({tv[i].name, " idle"}, 64'({hilo_busy, unit_start}), 64'd0);
         end
      end

      // Both pipes request DIV with rr=0: pipe 0 first, pipe 1 in the IDLE cycle after done.
      @(negedge clock);
      req_valid = 2'b11; req_op0 = OP_DIV; req_op1 = OP_DIV; req_a0 = 50; req_a1 = 60;
      #1;
      chk("div2 first_grant", 64'(grant), 64'h1);
      k = 0; nd = -1;
      do begin
         @(negedge clock); #1;
         k++;
         if (done === 1'b1) nd = k;
      end while (grant === 2'b00 && k < 80);
      chk("div2 done0_cycle", 64'(nd), 64'(DIVC + 1));
      chk("div2 regrant_cycle", 64'(k), 64'(DIVC + 2));
      chk("div2 second_grant", 64'(grant), 64'h2);
      @(negedge clock);
      req_valid = 2'b00;
      #1;
      wait_done(DIVC, 1'b1, 60, "div2_pipe1");
      @(negedge clock);
      req_valid = 2'b11; req_op0 = OP_MUL; req_op1 = OP_MUL; req_a0 = 1; req_a1 = 2;
      #1;
      chk("div2 rr_after", 64'(grant), 64'h1);
      @(negedge clock);
      req_valid = 2'b00;
      #1;
      wait_done(MULC, 1'b0, 1, "rr_probe");

      // Flush at count=10 of a DIV, then a MUL granted as soon as flush drops.
      @(negedge clock);
      req_valid = 2'b01; req_op0 = OP_DIV; req_a0 = 77;
      #1;
      chk("flush div_grant", 64'(grant), 64'h1);
      @(negedge clock);
      req_valid = 2'b00;
      nd = 0;
      for (int c = 1; c < 10; c++) begin
         #1;
         if (done === 1'b1) nd++;
         @(negedge clock);
      end
      flush = 1'b1; req_valid = 2'b10; req_op1 = OP_MUL; req_a1 = 3; req_b1 = 4;
      #1;
      chk("flush grant_blocked", 64'(grant), 64'h0);
      chk("flush no_done", 64'(nd + int'(done)), 64'd0);
      @(negedge clock);
      flush = 1'b0;
      #1;
      chk("flush idle", 64'({hilo_busy, unit_start, done}), 64'd0);
      chk("flush regrant", 64'(grant), 64'h2);
      @(negedge clock);
      req_valid = 2'b00;
      #1;
      chk("flush mul_ab", {unit_a, unit_b}, {32'd3, 32'd4});
      wait_done(MULC, 1'b1, 3, "post_flush_mul");

      // Flush while IDLE suppresses a pending grant.
      @(negedge clock);
      flush = 1'b1; req_valid = 2'b01; req_op0 = OP_MUL;
      #1;
      chk("flush_idle grant", 64'(grant), 64'h0);
      @(negedge clock);
      flush = 1'b0; req_valid = 2'b00;
      #1;
      chk("flush_idle no_busy", 64'({hilo_busy, unit_start}), 64'd0);

      // Reset at count=3 of a MUL owned by pipe 1.
      @(negedge clock);
      req_valid = 2'b10; req_op1 = OP_MUL; req_u = 2'b10; req_a1 = 8; req_b1 = 9;
      #1;
      chk("rst grant", 64'(grant), 64'h2);
      @(negedge clock);
      repeat (2) @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("rst outputs", 64'({grant, unit_start, done, done_id, hilo_busy, unit_u}), 64'd0);
      chk("rst unit_op", 64'(unit_op), 64'(OP_NONE));
      chk("rst unit_ab", {unit_a, unit_b}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1; req_valid = 2'b00; req_u = 2'b00;
      nd = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (done === 1'b1 || hilo_busy === 1'b1) nd++;
         @(negedge clock);
      end
      chk("rst no_done_after", 64'(nd), 64'd0);

      // Pipe 1 holds a MUL request: grants every MUL_CYCLES+2 cycles.
      req_valid = 2'b10; req_op1 = OP_MUL; req_a1 = 5;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (grant !== 2'b00) g.push_back(c);
         @(negedge clock);
      end
      req_valid = 2'b00;
      chk("b2b grant_count", 64'(g.size()), 64'd5);
      for (int j = 1; j < 4; j++) begin
         if (j < g.size()) chk("b2b spacing", 64'(g[j] - g[j-1]), 64'(MULC + 2));
         else chk("b2b spacing_missing", 64'(j), 64'(g.size()));
      end

      repeat (10) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
